// File: rtl/ps_req_issuer_if.sv
// Handshake bundle between ps_req_issuer, its clients and the priority selector.
interface ps_req_issuer_if;
    logic [3:0] push_valid;
    logic [3:0] push_ready;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic       owner_valid;
    logic [1:0] owner;
    logic       busy;
    logic       hold_done;
    logic       error;
    logic [3:0] starve;

    // Issuer side
    modport master (
        input  push_valid, gnt,
        output push_ready, req, en, owner_valid, owner, busy, hold_done, error, starve
    );

    // Client / selector side
    modport slave (
        output push_valid, gnt,
        input  push_ready, req, en, owner_valid, owner, busy, hold_done, error, starve
    );
endinterface

// File: rtl/ps_req_issuer.sv
// ps_req_issuer: queues per-client grant requests, drives a fixed-priority
// selector (req/en), accepts its one-hot gnt and holds the winner for
// HOLD_CYCLES cycles. Illegal gnt values and push overflow set a sticky error.
// Optional macro PS_REQ_ISSUER_STARVE_CNT_EN adds per-client starvation flags.
module ps_req_issuer #(
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    ps_req_issuer_if.master bus
);
    localparam int unsigned N      = 4;
    localparam int unsigned PMAX   = (1 << CNT_W) - 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    pending [N];
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          owner_q;
    logic                owner_valid_q;
    logic                busy_q;
    logic                hold_done_q;
    logic                error_q;

    logic [N-1:0]        ready_c;
    logic [N-1:0]        req_c;
    logic [N-1:0]        push_acc;
    logic                overflow;
    logic [1:0]          gnt_idx;
    logic                gnt_onehot;
    logic                accept;
    logic                proto_err;

    // Client-facing ready and selector-facing req, straight from registered state
    always_comb begin
        ready_c = '0;
        req_c   = '0;
        for (int i = 0; i < N; i++) begin
            ready_c[i] = (pending[i] != CNT_W'(PMAX));
            req_c[i]   = (state == IDLE) && (pending[i] != '0);
        end
    end

    // Grant decode, legality check and push acceptance
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) gnt_idx = 2'(i);
        end
        gnt_onehot = (bus.gnt != '0) && ((bus.gnt & (bus.gnt - 4'd1)) == '0);
        accept     = (state == IDLE) && gnt_onehot && (pending[gnt_idx] != '0);
        proto_err  = (bus.gnt != '0) && !accept;
        push_acc   = bus.push_valid & ready_c;
        overflow   = |(bus.push_valid & ~ready_c);
    end

    // Tenure FSM, pending counters and registered status outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            hold_done_q   <= 1'b0;
            error_q       <= 1'b0;
            for (int i = 0; i < N; i++) pending[i] <= '0;
        end else begin
            owner_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                pending[i] <= pending[i] + CNT_W'(push_acc[i]) - CNT_W'(accept && bus.gnt[i]);
            end
            if (proto_err || overflow) error_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= HOLD;
                        owner_q       <= gnt_idx;
                        owner_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        hold_cnt      <= HOLD_W'(HOLD_CYCLES - 1);
                        hold_done_q   <= (HOLD_CYCLES == 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        hold_done_q <= 1'b0;
                    end else begin
                        hold_cnt    <= hold_cnt - HOLD_W'(1);
                        hold_done_q <= (hold_cnt == HOLD_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PS_REQ_ISSUER_STARVE_CNT_EN
    localparam int unsigned WAIT_W   = $clog2(STARVE_LIMIT) + 1;
    localparam int unsigned WAIT_MAX = (1 << WAIT_W) - 1;

    logic [WAIT_W-1:0] wait_cnt [N];
    logic [N-1:0]      starve_c;

    // Saturating per-client wait counters; observational only
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((pending[i] == '0) || (accept && bus.gnt[i])) begin
                    wait_cnt[i] <= '0;
                end else if (req_c[i] && !bus.gnt[i] && (wait_cnt[i] != WAIT_W'(WAIT_MAX))) begin
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                end
            end
        end
    end

    // Starvation flags from registered wait counts
    always_comb begin
        starve_c = '0;
        for (int i = 0; i < N; i++) starve_c[i] = (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
    end

    assign bus.starve = starve_c;
`else
    assign bus.starve = 4'b0000;
`endif

    assign bus.push_ready  = ready_c;
    assign bus.req         = req_c;
    assign bus.en          = (state == IDLE);
    assign bus.owner_valid = owner_valid_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.hold_done   = hold_done_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_ps_req_issuer.sv
// Bench for ps_req_issuer: directed vector table, hand sequences for overflow
// and reset-in-tenure, and randomized traffic against a queue-level model.
module tb_ps_req_issuer;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned HOLD_CYCLES  = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int PMAX     = (1 << CNT_W) - 1;
    localparam int WAIT_MAX = (1 << ($clog2(STARVE_LIMIT) + 1)) - 1;

    logic clock = 1'b0;
    logic reset_n;

    ps_req_issuer_if bus();

    ps_req_issuer #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending counts, remaining tenure cycles, last owner
    bit m_known = 1'b0;
    int m_pend [4];
    int m_hold;
    bit m_ov;
    int m_own;
    bit m_err;
    int m_wait [4];

    typedef struct {
        logic       rstn;
        logic [3:0] pv;
        bit         frc;
        logic [3:0] gv;
        logic [3:0] e_req;
        logic       e_busy;
        logic       e_ov;
        logic [1:0] e_own;
        logic       e_hd;
        logic       e_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = (m_hold == 0) && (m_pend[i] > 0);
        return r;
    endfunction

    // Fixed-priority selector attached to the issuer: highest requesting bit wins
    function automatic logic [3:0] sel(input logic [3:0] r, input logic e);
        logic [3:0] g;
        g = '0;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && e) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] m_starve();
        logic [3:0] s;
        s = '0;
`ifdef PS_REQ_ISSUER_STARVE_CNT_EN
        for (int i = 0; i < 4; i++) s[i] = (m_wait[i] >= int'(STARVE_LIMIT));
`endif
        return s;
    endfunction

    task automatic model_check();
        chk("req",         bus.req,         m_req());
        chk("en",          bus.en,          m_hold == 0);
        begin
            logic [3:0] pr;
            for (int i = 0; i < 4; i++) pr[i] = (m_pend[i] < PMAX);
            chk("push_ready", bus.push_ready, pr);
        end
        chk("busy",        bus.busy,        m_hold > 0);
        chk("owner_valid", bus.owner_valid, m_ov);
        chk("owner",       bus.owner,       m_own);
        chk("hold_done",   bus.hold_done,   m_hold == 1);
        chk("error",       bus.error,       m_err);
        chk("starve",      bus.starve,      m_starve());
    endtask

    task automatic model_update(input logic rstn, input logic [3:0] pv, input logic [3:0] g);
        logic [3:0] r;
        int k;
        bit ok;
        if (!rstn) begin
            m_known = 1'b1;
            m_hold  = 0;
            m_ov    = 1'b0;
            m_own   = 0;
            m_err   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_wait[i] = 0;
            end
            return;
        end
        r = m_req();
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        ok = (m_hold == 0) && ($countones(g) == 1) && (m_pend[k] > 0);
        if ((g != 4'b0) && !ok) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((m_pend[i] == 0) || (ok && (k == i))) m_wait[i] = 0;
            else if (r[i] && !g[i] && (m_wait[i] < WAIT_MAX)) m_wait[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            if (pv[i]) begin
                if (m_pend[i] == PMAX) m_err = 1'b1;
                else m_pend[i]++;
            end
            if (ok && (k == i)) m_pend[i]--;
        end
        m_ov = ok;
        if (ok) begin
            m_own  = k;
            m_hold = HOLD_CYCLES;
        end else if (m_hold > 0) begin
            m_hold--;
        end
    endtask

    // Apply inputs for one cycle and compare every output with the model
    task automatic drive(input logic rstn, input logic [3:0] pv, input bit frc, input logic [3:0] gv);
        reset_n        = rstn;
        bus.push_valid = pv;
        bus.gnt        = frc ? gv : sel(m_req(), m_hold == 0);
        #1;
        if (m_known) model_check();
    endtask

    task automatic tick();
        @(posedge clock);
        model_update(reset_n, bus.push_valid, bus.gnt);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0, 1'b1, 4'b0);
        tick();
        drive(1'b0, 4'b0, 1'b1, 4'b0);
        tick();
    endtask

    function automatic vec_t v(input logic rstn, input logic [3:0] pv, input bit frc, input logic [3:0] gv,
                               input logic [3:0] e_req, input logic e_busy, input logic e_ov,
                               input logic [1:0] e_own, input logic e_hd, input logic e_err);
        vec_t x;
        x.rstn = rstn; x.pv = pv; x.frc = frc; x.gv = gv;
        x.e_req = e_req; x.e_busy = e_busy; x.e_ov = e_ov;
        x.e_own = e_own; x.e_hd = e_hd; x.e_err = e_err;
        return x;
    endfunction

    initial begin
        reset_n        = 1'b0;
        bus.push_valid = '0;
        bus.gnt        = '0;
        #2;

        // Reset then idle
        do_reset();
        drive(1'b1, 4'b0, 1'b1, 4'b0);
        chk("rst.req",        bus.req,        4'b0000);
        chk("rst.en",         bus.en,         1'b1);
        chk("rst.busy",       bus.busy,       1'b0);
        chk("rst.error",      bus.error,      1'b0);
        chk("rst.push_ready", bus.push_ready, 4'b1111);
        tick();

        // Single grant, three-way priority drain, then protocol errors
        vt.push_back(v(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0100, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 2, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 2, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 2, 1, 0));
        vt.push_back(v(1, 4'b1011, 0, 0, 4'b0000, 0, 0, 2, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b1011, 0, 0, 2, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 3, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 1, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0011, 0, 0, 3, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 1, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 1, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 1, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 1, 1, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0001, 0, 0, 1, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 1, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 1, 4'b0110, 4'b0000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vt.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vt.push_back(v(1, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vt.push_back(v(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        vt.push_back(v(1, 4'b1000, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b1000, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 4'b0000, 1, 4'b1000, 4'b0000, 1, 1, 3, 0, 0));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 0, 1));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 0, 1));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 1, 0, 3, 1, 1));
        vt.push_back(v(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 3, 0, 1));

        foreach (vt[i]) begin
            drive(vt[i].rstn, vt[i].pv, vt[i].frc, vt[i].gv);
            chk($sformatf("vec%0d.req", i),   bus.req,         vt[i].e_req);
            chk($sformatf("vec%0d.busy", i),  bus.busy,        vt[i].e_busy);
            chk($sformatf("vec%0d.ov", i),    bus.owner_valid, vt[i].e_ov);
            chk($sformatf("vec%0d.owner", i), bus.owner,       vt[i].e_own);
            chk($sformatf("vec%0d.hd", i),    bus.hold_done,   vt[i].e_hd);
            chk($sformatf("vec%0d.err", i),   bus.error,       vt[i].e_err);
            tick();
        end

        // Pending saturation on client 1, then overflow and recovery after one grant
        do_reset();
        for (int n = 0; n < PMAX; n++) begin
            drive(1'b1, 4'b0010, 1'b1, 4'b0000);
            tick();
        end
        drive(1'b1, 4'b0000, 1'b1, 4'b0000);
        chk("ovf.ready_full", bus.push_ready, 4'b1101);
        chk("ovf.err_before", bus.error,      1'b0);
        tick();
        drive(1'b1, 4'b0010, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 4'b0000, 0, 4'b0000);
        chk("ovf.err_set", bus.error, 1'b1);
        chk("ovf.req",     bus.req,   4'b0010);
        tick();
        drive(1'b1, 4'b0000, 1'b1, 4'b0000);
        chk("ovf.ready_back", bus.push_ready, 4'b1111);
        chk("ovf.owner",      bus.owner,      2'd1);
        tick();
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 4'b0000, 1'b1, 4'b0000);
            tick();
        end

        // Reset on the second tenure cycle aborts without hold_done
        do_reset();
        drive(1'b1, 4'b0100, 0, 4'b0);
        tick();
        drive(1'b1, 4'b0000, 0, 4'b0);
        tick();
        drive(1'b1, 4'b0000, 0, 4'b0);
        chk("mid.busy1", bus.busy, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 0, 4'b0);
        chk("mid.busy2", bus.busy, 1'b1);
        tick();
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 4'b0000, 1'b1, 4'b0);
            chk($sformatf("mid.busy_off%0d", n), bus.busy,       1'b0);
            chk($sformatf("mid.no_hd%0d", n),    bus.hold_done,  1'b0);
            chk($sformatf("mid.ready%0d", n),    bus.push_ready, 4'b1111);
            tick();
        end

        // Client 0 waiting behind steady client-3 traffic
        do_reset();
        drive(1'b1, 4'b1001, 0, 4'b0);
        tick();
        for (int n = 0; n < 60; n++) begin
            logic [3:0] p;
            p = ((m_pend[3] < 2) && (n % 4 == 0)) ? 4'b1000 : 4'b0000;
            drive(1'b1, p, 0, 4'b0);
            tick();
        end
        drive(1'b1, 4'b0000, 1'b1, 4'b0);
`ifdef PS_REQ_ISSUER_STARVE_CNT_EN
        chk("starve.client0", bus.starve, 4'b0001);
`else
        chk("starve.off", bus.starve, 4'b0000);
`endif
        tick();

        // Randomized traffic with occasional illegal grants and resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] p;
            logic       r;
            bit         f;
            logic [3:0] g;
            for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 17) == 0);
            f = ($urandom_range(0, 39) == 0);
            g = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 119) != 0);
            drive(r, p, f, g);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
